// File: rtl/flop_bank_mm.sv
// flop_bank_mm: multi-mode WIDTH-bit register (D/T/JK/shift/inc/clear) with change, shift-out and wrap pulses.
// Shift modes are built only when FLOP_BANK_SHIFT_EN is defined; otherwise modes 4 and 5 hold.
module flop_bank_mm #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic             chg,
    output logic             sout,
    output logic             wrap
);
    logic [WIDTH-1:0] nxt;
    logic             nxt_sout;
    logic             nxt_wrap;

    always_comb begin
        nxt      = q;
        nxt_sout = 1'b0;
        nxt_wrap = 1'b0;
        case (mode)
            3'd1: nxt = d;
            3'd2: nxt = q ^ d;
            3'd3: nxt = (d & ~q) | (~k & q);
`ifdef FLOP_BANK_SHIFT_EN
            3'd4: begin
                nxt      = {q[WIDTH-2:0], sin};
                nxt_sout = q[WIDTH-1];
            end
            3'd5: begin
                nxt      = {sin, q[WIDTH-1:1]};
                nxt_sout = q[0];
            end
`endif
            3'd6: begin
                nxt      = q + 1'b1;
                nxt_wrap = &q;
            end
            3'd7: nxt = '0;
            default: nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= RST_VAL;
            chg  <= 1'b0;
            sout <= 1'b0;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= nxt;
            chg  <= nxt != q;
            sout <= nxt_sout;
            wrap <= nxt_wrap;
        end else begin
            chg  <= 1'b0;
            sout <= 1'b0;
            wrap <= 1'b0;
        end
    end

    assign q_b = ~q;

`ifndef FLOP_BANK_SHIFT_EN
    logic unused_sin;
    assign unused_sin = sin;
`endif
endmodule

// File: tb/tb_flop_bank_mm.sv
// tb_flop_bank_mm: directed and randomized checks of flop_bank_mm against an arithmetic reference model.
module tb_flop_bank_mm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = '0;
    logic [7:0] d = '0;
    logic [7:0] k = '0;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic [7:0] q_b;
    logic       chg;
    logic       sout;
    logic       wrap;

    int n_chk = 0;
    int n_pass = 0;
    int mq, mchg, msout, mwrap;

    flop_bank_mm #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .k(k), .sin(sin),
        .q(q), .q_b(q_b), .chg(chg), .sout(sout), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"}, int'(q), mq);
        check({tag, ".q_b"}, int'(q_b), 255 - mq);
        check({tag, ".chg"}, int'(chg), mchg);
        check({tag, ".sout"}, int'(sout), msout);
        check({tag, ".wrap"}, int'(wrap), mwrap);
    endtask

    // Reference: integer arithmetic on the register value, one edge at a time.
    task automatic model(input int e, input int m, input int dv, input int kv, input int s);
        int nq, jb, kb, qb;
        nq = mq;
        msout = 0;
        mwrap = 0;
        if (e == 0) begin
            mchg = 0;
            return;
        end
        case (m)
            1: nq = dv;
            2: nq = mq ^ dv;
            3: begin
                nq = 0;
                for (int i = 0; i < 8; i++) begin
                    jb = (dv >> i) & 1;
                    kb = (kv >> i) & 1;
                    qb = (mq >> i) & 1;
                    if (jb == 1 && kb == 1) qb = 1 - qb;
                    else if (jb == 1) qb = 1;
                    else if (kb == 1) qb = 0;
                    nq += qb << i;
                end
            end
`ifdef FLOP_BANK_SHIFT_EN
            4: begin nq = (mq * 2 + s) % 256; msout = mq / 128; end
            5: begin nq = mq / 2 + s * 128; msout = mq % 2; end
`endif
            6: begin nq = (mq + 1) % 256; mwrap = (mq == 255) ? 1 : 0; end
            7: nq = 0;
            default: nq = mq;
        endcase
        mchg = (nq != mq) ? 1 : 0;
        mq = nq;
    endtask

    task automatic step(input string tag, input logic e, input logic [2:0] m,
                        input logic [7:0] dv, input logic [7:0] kv, input logic s);
        en = e; mode = m; d = dv; k = kv; sin = s;
        model(int'(e), int'(m), int'(dv), int'(kv), int'(s));
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Called 1 ns after a rising edge; the pulse finishes well before the next one.
    task automatic pulse_rst(input string tag);
        rst = 1'b0;
        #1;
        mq = 8'hA5; mchg = 0; msout = 0; mwrap = 0;
        check_all(tag);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        mq = 0; mchg = 0; msout = 0; mwrap = 0;
        #1;
        rst = 1'b0;
        #1;
        check("rst.q", int'(q), 8'hA5);
        check("rst.q_b", int'(q_b), 8'h5A);
        mq = 8'hA5;
        check_all("rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2;
        rst = 1'b1;
        step("hold0", 1, 0, 8'h00, 8'h00, 0);
        step("hold1", 1, 0, 8'h00, 8'h00, 0);
        check("hold.q", int'(q), 8'hA5);
        step("load3c", 1, 1, 8'h3C, 8'h00, 0);
        check("load.chg", int'(chg), 1);
        step("tog0f", 1, 2, 8'h0F, 8'h00, 0);
        check("tog.q", int'(q), 8'h33);
        step("tog00", 1, 2, 8'h00, 8'h00, 0);
        step("en0", 0, 1, 8'hFF, 8'h00, 0);
        check("en0.q", int'(q), 8'h33);
        step("load33", 1, 1, 8'h33, 8'h00, 0);
        check("loadeq.chg", int'(chg), 0);
        step("loadf0", 1, 1, 8'hF0, 8'h00, 0);
        step("jk_a", 1, 3, 8'h0F, 8'hF0, 0);
        check("jk.q", int'(q), 8'h0F);
        step("jk_b", 1, 3, 8'hFF, 8'hFF, 0);
        check("jk_inv.q", int'(q), 8'hF0);
        step("jk_c", 1, 3, 8'h00, 8'h00, 0);
        step("load81", 1, 1, 8'h81, 8'h00, 0);
        step("shl", 1, 4, 8'h00, 8'h00, 0);
        step("shr", 1, 5, 8'h00, 8'h00, 1);
        step("loadff", 1, 1, 8'hFF, 8'h00, 0);
        step("shl_ones", 1, 4, 8'h00, 8'h00, 1);
        step("loadfe", 1, 1, 8'hFE, 8'h00, 0);
        step("inc_fe", 1, 6, 8'h00, 8'h00, 0);
        step("inc_ff", 1, 6, 8'h00, 8'h00, 0);
        check("wrap.q", int'(q), 8'h00);
        check("wrap.wrap", int'(wrap), 1);
        step("inc_00", 1, 6, 8'h00, 8'h00, 0);
        step("load10", 1, 1, 8'h10, 8'h00, 0);
        step("inc_a", 1, 6, 8'h00, 8'h00, 0);
        step("inc_b", 1, 6, 8'h00, 8'h00, 0);
        pulse_rst("rst_mid");
        step("inc_resume", 1, 6, 8'h00, 8'h00, 0);
        check("resume.q", int'(q), 8'hA6);
        step("clr", 1, 7, 8'h00, 8'h00, 0);
        check("clr.q", int'(q), 8'h00);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_rst("rnd_rst");
            else if ($urandom_range(0, 15) == 0) step("rnd_ff", 1, 1, 8'hFF, 8'h00, 0);
            else step("rnd", $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom), 1'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
